// File: rtl/upc_loop_profiler_if.sv
`default_nettype none
// ============================================================================
// Module   : upc_loop_profiler_if
// Brief    : Record stream (valid/ready) carrying one loop-profile record.
// Revision : 1.0 - initial release
// ============================================================================
interface upc_loop_profiler_if #(
  parameter int CNT_W  = 32,
  parameter int ITER_W = 16
);
  logic              rec_valid;
  logic              rec_ready;
  logic [CNT_W-1:0]  rec_latency;
  logic [ITER_W-1:0] rec_iters;
  logic [CNT_W-1:0]  rec_stalls;
  logic              rec_overflow;
  logic [7:0]        rec_seq;

  modport master (
    output rec_valid, rec_latency, rec_iters, rec_stalls, rec_overflow, rec_seq,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_latency, rec_iters, rec_stalls, rec_overflow, rec_seq,
    output rec_ready
  );
endinterface
`default_nettype wire

// File: rtl/upc_loop_profiler.sv
`default_nettype none
// ============================================================================
// Module   : upc_loop_profiler
// Brief    : Per-invocation latency/iteration/stall profiler for an HLS loop,
//            records queued in a FWFT FIFO. Stall counting needs
//            UPC_PROFILER_STALL_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module upc_loop_profiler #(
  parameter int CNT_W      = 32,
  parameter int ITER_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                loop_start,
  input  logic                loop_done,
  input  logic                iter_fire,
  input  logic                stall,
  upc_loop_profiler_if.master rec,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  localparam int                c_AW       = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]     c_FULL     = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
  localparam logic [ITER_W-1:0] c_ITER_MAX = '1;
  localparam logic [0:0]        c_IDLE     = 1'b0;
  localparam logic [0:0]        c_RUN      = 1'b1;

  logic [0:0] r_state, w_state_nxt;
  logic       w_busy, w_start, w_push_req;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= c_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (loop_start) w_state_nxt = c_RUN;
      c_RUN:   if (loop_done)  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state == c_RUN);
    w_start    = (r_state == c_IDLE) && loop_start;
    w_push_req = (r_state == c_RUN) && loop_done;
  end

  // Next-count values include the current cycle, so the done cycle is counted
  logic [CNT_W-1:0]  r_lat, w_lat_nxt;
  logic [ITER_W-1:0] r_iter, w_iter_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              w_lat_sat, w_iter_sat, w_stl_sat;

  assign w_lat_sat  = (r_lat == c_CNT_MAX);
  assign w_lat_nxt  = w_lat_sat ? r_lat : r_lat + CNT_W'(1);
  assign w_iter_sat = iter_fire && (r_iter == c_ITER_MAX);
  assign w_iter_nxt = w_iter_sat ? r_iter : r_iter + ITER_W'(iter_fire);
  assign w_ovf_nxt  = r_ovf | w_lat_sat | w_iter_sat | w_stl_sat;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_lat  <= '0;
      r_iter <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start) begin
      r_lat  <= CNT_W'(1);
      r_iter <= ITER_W'(iter_fire);
      r_ovf  <= 1'b0;
    end else if (w_busy) begin
      r_lat  <= w_lat_nxt;
      r_iter <= w_iter_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

`ifdef UPC_PROFILER_STALL_COUNT_EN
  logic [CNT_W-1:0] r_stl, w_stl_nxt;

  assign w_stl_sat = stall && (r_stl == c_CNT_MAX);
  assign w_stl_nxt = w_stl_sat ? r_stl : r_stl + CNT_W'(stall);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    r_stl <= '0;
    else if (w_start) r_stl <= CNT_W'(stall);
    else if (w_busy)  r_stl <= w_stl_nxt;
  end
`else
  logic w_unused_stall;
  assign w_unused_stall = stall;
  assign w_stl_sat      = 1'b0;
`endif

  logic [7:0]  r_seq;
  logic [15:0] r_drop;

  logic [CNT_W-1:0]  r_mem_lat  [FIFO_DEPTH];
  logic [ITER_W-1:0] r_mem_iter [FIFO_DEPTH];
  logic              r_mem_ovf  [FIFO_DEPTH];
  logic [7:0]        r_mem_seq  [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              w_valid, w_full, w_pop, w_push, w_drop;

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_FULL);
  assign w_pop   = w_valid && rec.rec_ready;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req)                 r_seq  <= r_seq + 8'd1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_mem_lat[r_wr_ptr]  <= w_lat_nxt;
      r_mem_iter[r_wr_ptr] <= w_iter_nxt;
      r_mem_ovf[r_wr_ptr]  <= w_ovf_nxt;
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  assign rec.rec_valid    = w_valid;
  assign rec.rec_latency  = w_valid ? r_mem_lat[r_rd_ptr]  : '0;
  assign rec.rec_iters    = w_valid ? r_mem_iter[r_rd_ptr] : '0;
  assign rec.rec_overflow = w_valid ? r_mem_ovf[r_rd_ptr]  : 1'b0;
  assign rec.rec_seq      = w_valid ? r_mem_seq[r_rd_ptr]  : '0;

`ifdef UPC_PROFILER_STALL_COUNT_EN
  logic [CNT_W-1:0] r_mem_stl [FIFO_DEPTH];

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem_stl[r_wr_ptr] <= w_stl_nxt;
  end

  assign rec.rec_stalls = w_valid ? r_mem_stl[r_rd_ptr] : '0;
`else
  assign rec.rec_stalls = '0;
`endif

  assign drop_cnt = r_drop;
  assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_upc_loop_profiler.sv
`default_nettype none
// ============================================================================
// Module   : tb_upc_loop_profiler
// Brief    : Self-checking bench for upc_loop_profiler (record scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_upc_loop_profiler;
  localparam int CNT_W  = 8;
  localparam int ITER_W = 16;
  localparam int DEPTH  = 4;

  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic loop_start = 1'b0, loop_done = 1'b0, iter_fire = 1'b0, stall = 1'b0, rdy = 1'b0;
  logic [15:0] drop_cnt;
  logic        busy;

  upc_loop_profiler_if #(.CNT_W(CNT_W), .ITER_W(ITER_W)) rec_bus ();
  assign rec_bus.rec_ready = rdy;

  upc_loop_profiler #(.CNT_W(CNT_W), .ITER_W(ITER_W), .FIFO_DEPTH(DEPTH)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .loop_start (loop_start),
    .loop_done  (loop_done),
    .iter_fire  (iter_fire),
    .stall      (stall),
    .rec        (rec_bus),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [CNT_W-1:0]  lat;
    logic [ITER_W-1:0] it;
    logic [CNT_W-1:0]  st;
    logic              ovf;
    logic [7:0]        seq;
  } rec_t;

  typedef struct {
    int n; int it; int st; bit hold;
    int exp_lat; int exp_it; int exp_st; bit exp_ovf;
  } vec_t;

  rec_t exp_q[$];
  rec_t mon_act;
  int   n_checks = 0, n_fail = 0, m_seq = 0, m_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int stl_exp(input int s);
`ifdef UPC_PROFILER_STALL_COUNT_EN
    return s;
`else
    return 0;
`endif
  endfunction

  // Monitor: occupancy must match the model; every accepted record is compared
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      check("rec_valid", 64'(rec_bus.rec_valid), 64'(exp_q.size() != 0));
      if (rec_bus.rec_valid && rdy && exp_q.size() != 0) begin
        mon_act = {rec_bus.rec_latency, rec_bus.rec_iters, rec_bus.rec_stalls,
                   rec_bus.rec_overflow, rec_bus.rec_seq};
        check("record", 64'(mon_act), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic run_inv(input int n, input int it, input int st, input bit hold, input bit pop_done,
                         input int exp_lat, input int exp_it, input int exp_st, input bit exp_ovf);
    rec_t e;
    for (int c = 0; c < n; c++) begin
      loop_start = hold || (c == 0);
      iter_fire  = (c < it);
      stall      = (c < st);
      loop_done  = (c == n - 1);
      if (pop_done && c == n - 1) rdy = 1'b1;
      @(posedge ap_clk); #1;
      if (c == 0) check("busy_rise", 64'(busy), 64'd1);
      if (pop_done && c == n - 1) rdy = 1'b0;
    end
    loop_start = hold; loop_done = 1'b0; iter_fire = 1'b0; stall = 1'b0;
    check("busy_fall", 64'(busy), 64'd0);
    e.lat = CNT_W'(exp_lat);
    e.it  = ITER_W'(exp_it);
    e.st  = CNT_W'(stl_exp(exp_st));
    e.ovf = exp_ovf;
    e.seq = 8'(m_seq);
    m_seq = (m_seq + 1) % 256;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else if (m_drop < 65535) m_drop++;
  endtask

  task automatic drain();
    rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge ap_clk); #1;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{10,  5, 2, 1'b0,  10,  5, 2, 1'b0};
    tbl[1] = '{2,   0, 0, 1'b0,   2,  0, 0, 1'b0};
    tbl[2] = '{3,   3, 3, 1'b0,   3,  3, 3, 1'b0};
    tbl[3] = '{7,   1, 7, 1'b1,   7,  1, 7, 1'b0};
    tbl[4] = '{4,   2, 0, 1'b0,   4,  2, 0, 1'b0};
    tbl[5] = '{300, 10, 0, 1'b0, 255, 10, 0, 1'b1};
    tbl[6] = '{4,   0, 1, 1'b0,   4,  0, 1, 1'b0};

    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_valid",    64'(rec_bus.rec_valid),    64'd0);
    check("rst_latency",  64'(rec_bus.rec_latency),  64'd0);
    check("rst_iters",    64'(rec_bus.rec_iters),    64'd0);
    check("rst_stalls",   64'(rec_bus.rec_stalls),   64'd0);
    check("rst_overflow", 64'(rec_bus.rec_overflow), 64'd0);
    check("rst_seq",      64'(rec_bus.rec_seq),      64'd0);
    check("rst_drop",     64'(drop_cnt),             64'd0);
    check("rst_busy",     64'(busy),                 64'd0);
    ap_rst_n = 1'b1;
    rdy      = 1'b1;
    @(posedge ap_clk); #1;

    // Done while idle must not start anything or produce a record
    loop_done = 1'b1;
    @(posedge ap_clk); #1;
    loop_done = 1'b0;
    check("idle_done_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge ap_clk);
    #1;

    for (int i = 0; i < 7; i++)
      run_inv(tbl[i].n, tbl[i].it, tbl[i].st, tbl[i].hold, 1'b0,
              tbl[i].exp_lat, tbl[i].exp_it, tbl[i].exp_st, tbl[i].exp_ovf);
    drain();

    // Backpressure: four held, two dropped, then a push into a full FIFO with a same-cycle pop
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) run_inv(3, 1, 0, 1'b0, 1'b0, 3, 1, 0, 1'b0);
    check("drop_after_6", 64'(drop_cnt), 64'(m_drop));
    check("drop_is_2",    64'(drop_cnt), 64'd2);
    run_inv(3, 2, 1, 1'b0, 1'b1, 3, 2, 1, 1'b0);
    check("drop_full_pop", 64'(drop_cnt), 64'd2);
    drain();
    run_inv(5, 4, 2, 1'b0, 1'b0, 5, 4, 2, 1'b0);
    drain();

    // Reset in the middle of an invocation, with a record still queued
    rdy = 1'b0;
    run_inv(3, 1, 1, 1'b0, 1'b0, 3, 1, 1, 1'b0);
    loop_start = 1'b1;
    @(posedge ap_clk); #1;
    loop_start = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_busy",  64'(busy),              64'd0);
    check("midrst_valid", 64'(rec_bus.rec_valid), 64'd0);
    check("midrst_drop",  64'(drop_cnt),          64'd0);
    exp_q.delete();
    m_seq  = 0;
    m_drop = 0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    rdy = 1'b1;
    @(posedge ap_clk); #1;
    run_inv(6, 3, 7, 1'b0, 1'b0, 6, 3, 6, 1'b0);
    drain();
    check("final_drop", 64'(drop_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
